// File: rtl/stream_mux2x1_pkg.sv
// ============================================================================
// Module      : stream_mux2x1_pkg
// Description : Shared arbitration state encoding and defaults for the
//               two-input stream multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_mux2x1_pkg;

    localparam int c_DEFAULT_WIDTH    = 8;
    localparam int c_DEFAULT_LOCK_LEN = 4;
    localparam int c_CNT_W            = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_t;

    function automatic arb_state_t grant_of(input logic src);
        return src ? G1 : G0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_reg.sv
// ============================================================================
// Module      : stream_reg
// Description : Single-entry registered output stage (data, source index,
//               valid) with load/hold behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_reg
    import stream_mux2x1_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sel,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sel,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_sel;
    logic             r_valid;

    // A load always wins over a drain so a same-cycle transfer keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_sel   <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_sel   <= i_sel;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_sel   = r_sel;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/stream_mux2x1.sv
// ============================================================================
// Module      : stream_mux2x1
// Description : Two-source valid/ready stream multiplexer with round-robin
//               tie-break, bounded burst lock and a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux2x1
    import stream_mux2x1_pkg::*;
#(
    parameter int WIDTH    = c_DEFAULT_WIDTH,
    parameter int LOCK_LEN = c_DEFAULT_LOCK_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0_data,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1_data,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_sel
);

    localparam logic [c_CNT_W-1:0] c_LOCK = c_CNT_W'(LOCK_LEN);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                r_last;
    logic                w_last_nxt;
    logic                w_out_free;
    logic                w_own_sel;
    logic                w_own_valid;
    logic                w_oth_valid;
    logic                w_load;
    logic [WIDTH-1:0]    w_in_data;

    assign w_out_free  = ~o_valid | o_ready;
    assign w_own_sel   = (r_state == G1);
    assign w_own_valid = w_own_sel ? i1_valid : i0_valid;
    assign w_oth_valid = w_own_sel ? i0_valid : i1_valid;
    assign w_cnt_inc   = r_cnt + 8'd1;

    assign i0_ready  = (r_state == G0) & w_out_free;
    assign i1_ready  = (r_state == G1) & w_out_free;
    assign w_load    = (i0_valid & i0_ready) | (i1_valid & i1_ready);
    assign w_in_data = w_own_sel ? i1_data : i0_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                // On a tie the source that did not own the channel last goes first.
                if (i0_valid && i1_valid) begin
                    w_state_nxt = r_last ? G0 : G1;
                end else if (i0_valid) begin
                    w_state_nxt = G0;
                end else if (i1_valid) begin
                    w_state_nxt = G1;
                end
            end
            G0, G1: begin
                if (!w_own_valid) begin
                    w_state_nxt = w_oth_valid ? grant_of(~w_own_sel) : IDLE;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = w_own_sel;
                end else if (w_out_free) begin
                    if (w_cnt_inc == c_LOCK) begin
                        w_cnt_nxt = '0;
                        if (w_oth_valid) begin
                            w_state_nxt = grant_of(~w_own_sel);
                            w_last_nxt  = w_own_sel;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    stream_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_in_data),
        .i_sel   (w_own_sel),
        .i_ready (o_ready),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .o_valid (o_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_stream_mux2x1.sv
// ============================================================================
// Module      : tb_stream_mux2x1
// Description : Scoreboard-based bench for the two-source stream multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux2x1;

    localparam int W  = 8;
    localparam int LL = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] i0_data = '0;
    logic         i0_valid = 1'b0;
    logic         i0_ready;
    logic [W-1:0] i1_data = '0;
    logic         i1_valid = 1'b0;
    logic         i1_ready;
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         o_ready = 1'b1;
    logic         o_sel;

    always #5 clk = ~clk;

    stream_mux2x1 #(
        .WIDTH    (W),
        .LOCK_LEN (LL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i0_data  (i0_data),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i1_data  (i1_data),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_sel    (o_sel)
    );

    typedef struct {
        logic         sel;
        logic [W-1:0] data;
        int           cyc;
    } out_t;

    int           n_pass  = 0;
    int           n_total = 0;
    int           cyc     = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W:0]   sb[$];
    out_t         logq[$];
    logic [W:0]   sb_exp;
    logic         en0 = 1'b0;
    logic         en1 = 1'b0;
    logic         acc0 = 1'b0;
    logic         acc1 = 1'b0;
    int           first0 = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Source drivers: present queue heads, advance after each accepted beat.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            i0_valid = 1'b0;
            i1_valid = 1'b0;
        end else begin
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            acc0 = 1'b0;
            acc1 = 1'b0;
            if (en0 && q0.size() > 0) begin
                if (!i0_valid) first0 = cyc;
                i0_valid = 1'b1;
                i0_data  = q0[0];
            end else begin
                i0_valid = 1'b0;
                i0_data  = '0;
            end
            if (en1 && q1.size() > 0) begin
                i1_valid = 1'b1;
                i1_data  = q1[0];
            end else begin
                i1_valid = 1'b0;
                i1_data  = '0;
            end
        end
    end

    // Monitor: record accepts into the scoreboard, compare output transfers.
    always @(negedge clk) begin
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst) begin
            n_total++;
            if (i0_ready && i1_ready)
                $display("FAIL both_ready: got i0_ready=1 i1_ready=1, expected at most one");
            else
                n_pass++;
            if (o_valid && o_ready) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_extra: got sel=%0d data=%h, expected no beat", o_sel, o_data);
                end else begin
                    sb_exp = sb.pop_front();
                    if ({o_sel, o_data} !== sb_exp)
                        $display("FAIL sb_beat: got sel=%0d data=%h, expected sel=%0d data=%h",
                                 o_sel, o_data, sb_exp[W], sb_exp[W-1:0]);
                    else
                        n_pass++;
                end
                logq.push_back('{o_sel, o_data, cyc});
            end
            if (i0_valid && i0_ready) begin
                sb.push_back({1'b0, i0_data});
                acc0 = 1'b1;
            end
            if (i1_valid && i1_ready) begin
                sb.push_back({1'b1, i1_data});
                acc1 = 1'b1;
            end
        end
    end

    task automatic wait_drain(input int budget, input string nm);
        int   k    = 0;
        logic done = 1'b0;
        while (!done && k < budget) begin
            @(negedge clk);
            #1;
            k++;
            done = (q0.size() == 0) && (q1.size() == 0) && (sb.size() == 0) &&
                   !i0_valid && !i1_valid && !o_valid;
        end
        n_total++;
        if (!done) $display("FAIL %s: got timeout after %0d cycles, expected drain", nm, k);
        else n_pass++;
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int k = 0;
        while (logq.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_total++;
        if (logq.size() < n) $display("FAIL %s: got %0d beats, expected %0d", nm, logq.size(), n);
        else n_pass++;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        o_ready = 1'b1;
        q0.delete();
        q1.delete();
        sb.delete();
        logq.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_total++;
        if ({o_valid, o_sel, o_data, i0_ready, i1_ready} !== '0)
            $display("FAIL reset_outputs: got v=%0d s=%0d d=%h r0=%0d r1=%0d, expected all 0",
                     o_valid, o_sel, o_data, i0_ready, i1_ready);
        else n_pass++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({o_valid, i0_ready, i1_ready} !== 3'b000)
            $display("FAIL reset_idle: got v=%0d r0=%0d r1=%0d, expected 0 0 0",
                     o_valid, i0_ready, i1_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [W-1:0] exp_d[3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        logq.delete();
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) q0.push_back(exp_d[i]);
        en0 = 1'b1;
        wait_drain(50, "single_drain");
        en0 = 1'b0;
        n_total++;
        if (logq.size() != 3) $display("FAIL single_count: got %0d, expected 3", logq.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < logq.size(); i++) begin
            n_total++;
            if (logq[i].sel !== 1'b0 || logq[i].data !== exp_d[i] || logq[i].cyc != first0 + 2 + i)
                $display("FAIL single_beat%0d: got sel=%0d data=%h cyc=%0d, expected sel=0 data=%h cyc=%0d",
                         i, logq[i].sel, logq[i].data, logq[i].cyc, exp_d[i], first0 + 2 + i);
            else n_pass++;
        end
    endtask

    task automatic test_tie();
        int           n0 = 0;
        int           n1 = 0;
        logic         es;
        logic [W-1:0] ed;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'(8'hA0 + i));
            q1.push_back(8'(8'hB0 + i));
        end
        en0 = 1'b1;
        en1 = 1'b1;
        wait_drain(100, "tie_drain");
        en0 = 1'b0;
        en1 = 1'b0;
        n_total++;
        if (logq.size() != 16) $display("FAIL tie_count: got %0d, expected 16", logq.size());
        else n_pass++;
        for (int i = 0; i < 16 && i < logq.size(); i++) begin
            es = ((i / LL) % 2) == 1;
            if (es) begin
                ed = 8'(8'hB0 + n1);
                n1++;
            end else begin
                ed = 8'(8'hA0 + n0);
                n0++;
            end
            n_total++;
            if (logq[i].sel !== es || logq[i].data !== ed || logq[i].cyc != logq[0].cyc + i)
                $display("FAIL tie_beat%0d: got sel=%0d data=%h cyc=%0d, expected sel=%0d data=%h cyc=%0d",
                         i, logq[i].sel, logq[i].data, logq[i].cyc, es, ed, logq[0].cyc + i);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logq.delete();
        @(posedge clk);
        #2;
        for (int i = 0; i < 6; i++) q1.push_back(8'(8'hC0 + i));
        en1 = 1'b1;
        wait_log(2, 50, "bp_start");
        @(posedge clk);
        #2;
        o_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_total++;
            if (sb.size() == 0 || o_valid !== 1'b1 || o_sel !== 1'b1 ||
                o_data !== sb[0][W-1:0] || i1_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got v=%0d s=%0d d=%h r1=%0d, expected v=1 s=1 held beat r1=0",
                         k, o_valid, o_sel, o_data, i1_ready);
            else n_pass++;
        end
        @(posedge clk);
        #2;
        o_ready = 1'b1;
        wait_drain(50, "bp_drain");
        en1 = 1'b0;
        n_total++;
        if (logq.size() != 6) $display("FAIL bp_count: got %0d, expected 6", logq.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < logq.size(); i++) begin
            n_total++;
            if (logq[i].sel !== 1'b1 || logq[i].data !== 8'(8'hC0 + i))
                $display("FAIL bp_beat%0d: got sel=%0d data=%h, expected sel=1 data=%h",
                         i, logq[i].sel, logq[i].data, 8'(8'hC0 + i));
            else n_pass++;
        end
    endtask

    task automatic test_owner_drop();
        logic         exp_s[5];
        logic [W-1:0] exp_d[5];
        exp_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_d = '{8'hD0, 8'hD1, 8'hE0, 8'hE1, 8'hE2};
        apply_reset();
        q0.push_back(8'hD0);
        q0.push_back(8'hD1);
        for (int i = 0; i < 3; i++) q1.push_back(8'(8'hE0 + i));
        en0 = 1'b1;
        en1 = 1'b1;
        wait_log(3, 50, "drop_switch");
        n_total++;
        if (dut.r_last !== 1'b0) $display("FAIL drop_last: got %0d, expected 0", dut.r_last);
        else n_pass++;
        wait_drain(50, "drop_drain");
        en0 = 1'b0;
        en1 = 1'b0;
        n_total++;
        if (logq.size() != 5) $display("FAIL drop_count: got %0d, expected 5", logq.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < logq.size(); i++) begin
            n_total++;
            if (logq[i].sel !== exp_s[i] || logq[i].data !== exp_d[i])
                $display("FAIL drop_beat%0d: got sel=%0d data=%h, expected sel=%0d data=%h",
                         i, logq[i].sel, logq[i].data, exp_s[i], exp_d[i]);
            else n_pass++;
        end
        if (logq.size() >= 3) begin
            n_total++;
            if (logq[2].cyc != logq[1].cyc + 2)
                $display("FAIL drop_gap: got cyc=%0d, expected cyc=%0d", logq[2].cyc, logq[1].cyc + 2);
            else n_pass++;
        end
    endtask

    task automatic test_lock_alone();
        logq.delete();
        @(posedge clk);
        #2;
        for (int i = 0; i < 10; i++) q1.push_back(8'(8'hF0 + i));
        en1 = 1'b1;
        wait_drain(60, "lock_drain");
        en1 = 1'b0;
        n_total++;
        if (logq.size() != 10) $display("FAIL lock_count: got %0d, expected 10", logq.size());
        else n_pass++;
        for (int i = 0; i < 10 && i < logq.size(); i++) begin
            n_total++;
            if (logq[i].sel !== 1'b1 || logq[i].data !== 8'(8'hF0 + i) || logq[i].cyc != logq[0].cyc + i)
                $display("FAIL lock_beat%0d: got sel=%0d data=%h cyc=%0d, expected sel=1 data=%h cyc=%0d",
                         i, logq[i].sel, logq[i].data, logq[i].cyc, 8'(8'hF0 + i), logq[0].cyc + i);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int k = 0;
        logq.delete();
        @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) q0.push_back(8'(8'h51 + i));
        en0 = 1'b1;
        o_ready = 1'b0;
        while (o_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_total++;
        if (o_valid !== 1'b1) $display("FAIL arst_prime: got o_valid=%0d, expected 1", o_valid);
        else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_total++;
        if ({o_valid, o_sel, o_data, i0_ready, i1_ready} !== '0)
            $display("FAIL arst_outputs: got v=%0d s=%0d d=%h r0=%0d r1=%0d, expected all 0",
                     o_valid, o_sel, o_data, i0_ready, i1_ready);
        else n_pass++;
        q0.delete();
        q1.delete();
        sb.delete();
        logq.delete();
        en0 = 1'b0;
        o_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        q0.push_back(8'h61);
        q1.push_back(8'h71);
        en0 = 1'b1;
        en1 = 1'b1;
        wait_drain(40, "arst_drain");
        en0 = 1'b0;
        en1 = 1'b0;
        n_total++;
        if (logq.size() != 2 || logq[0].sel !== 1'b0 || logq[0].data !== 8'h61 ||
            logq[1].sel !== 1'b1 || logq[1].data !== 8'h71)
            $display("FAIL arst_regrant: got %0d beats first_sel=%0d, expected 2 beats sel 0 then 1",
                     logq.size(), (logq.size() > 0) ? logq[0].sel : 1'bx);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_owner_drop();
        test_lock_alone();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
